// File: rtl/mux_scan_ctrl_if.sv
// Port bundle for the 4:1 mux select sequencer: scan request, mask, mux feedback and results.
// Handshake: start is a level request, taken on any edge where the controller is in IDLE or FIN;
// done is a one-cycle completion pulse with sample valid in that cycle and held afterwards.
interface mux_scan_ctrl_if;
  logic       start;
  logic       cont;
  logic [3:0] ch_en;
  logic       y;
  logic       s1;
  logic       s0;
  logic       busy;
  logic       done;
  logic [3:0] sample;
  logic [1:0] dbg_state;

  modport master (
    output start, cont, ch_en, y,
    input  s1, s0, busy, done, sample, dbg_state
  );

  modport slave (
    input  start, cont, ch_en, y,
    output s1, s0, busy, done, sample, dbg_state
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Select-line sequencer for a 4:1 mux: walks the enabled channels in ascending order,
// waits SETTLE cycles after each select change, then captures y into the result word.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic           clk,
  input  logic           rst,
  mux_scan_ctrl_if.slave bus
);

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] en_q, en_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] shadow_q, shadow_d;
  logic [3:0] sample_q, sample_d;

  logic       accept;
  logic [3:0] captured;
  logic [3:0] higher;

  function automatic logic [1:0] lowest_bit(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  // Channels strictly above the given index.
  function automatic logic [3:0] above_mask(input logic [1:0] i);
    case (i)
      2'd0:    return 4'b1110;
      2'd1:    return 4'b1100;
      2'd2:    return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      en_q     <= 4'd0;
      sel_q    <= 2'd0;
      cnt_q    <= 4'd0;
      shadow_q <= 4'd0;
      sample_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      sample_q <= sample_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    sample_d = sample_q;

    captured         = shadow_q;
    captured[sel_q]  = bus.y;
    higher           = en_q & above_mask(sel_q);
    accept           = ((state_q == IDLE) && bus.start) ||
                       ((state_q == FIN) && (bus.start || bus.cont));

    if (accept) begin
      en_d     = bus.ch_en;
      shadow_d = 4'd0;
      if (bus.ch_en == 4'd0) begin
        // Nothing to scan: report an all-zero result straight away, select untouched.
        sample_d = 4'd0;
        state_d  = FIN;
      end else begin
        sel_d   = lowest_bit(bus.ch_en);
        cnt_d   = SETTLE_C;
        state_d = WAIT;
      end
    end else begin
      case (state_q)
        WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else if (higher != 4'd0) begin
            shadow_d = captured;
            sel_d    = lowest_bit(higher);
            cnt_d    = SETTLE_C;
          end else begin
            sample_d = captured;
            state_d  = FIN;
          end
        end
        FIN:     state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  assign bus.s1        = sel_q[1];
  assign bus.s0        = sel_q[0];
  assign bus.busy      = (state_q == WAIT);
  assign bus.done      = (state_q == FIN);
  assign bus.sample    = sample_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: a SETTLE=1 instance for single scans and a SETTLE=0
// instance for continuous mode, each fed by a behavioural 4:1 mux.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] d;
  logic [3:0] d0;

  mux_scan_ctrl_if bus ();
  mux_scan_ctrl_if bus0 ();

  mux_scan_ctrl #(.SETTLE(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  mux_scan_ctrl #(.SETTLE(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  assign bus.y  = d[{bus.s1, bus.s0}];
  assign bus0.y = d0[{bus0.s1, bus0.s0}];

  always #5 clk = ~clk;

  int         tests_run;
  int         tests_failed;
  logic [3:0] exp_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;  bus.cont = 1'b0;  bus.ch_en = 4'd0;
    bus0.start = 1'b0; bus0.cont = 1'b0; bus0.ch_en = 4'd0;
    d = 4'd0; d0 = 4'd0;
    step();
    step();
    tests_run++;
    if ({bus.s1, bus.s0} !== 2'b00) begin tests_failed++; $display("FAIL reset_sel got %b exp 00", {bus.s1, bus.s0}); end
    tests_run++;
    if (bus.sample !== 4'b0000) begin tests_failed++; $display("FAIL reset_sample got %b exp 0000", bus.sample); end
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin tests_failed++; $display("FAIL reset_flags got busy=%b done=%b exp 0 0", bus.busy, bus.done); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_full_scan();
    d = 4'b1010; bus.ch_en = 4'b1111; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tests_run++;
      if ({bus.s1, bus.s0} !== 2'(k >> 1) || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        tests_failed++;
        $display("FAIL full_step%0d got sel=%b busy=%b done=%b exp sel=%b busy=1 done=0", k, {bus.s1, bus.s0}, bus.busy, bus.done, 2'(k >> 1));
      end
      step();
    end
    tests_run++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin tests_failed++; $display("FAIL full_done got done=%b busy=%b exp 1 0", bus.done, bus.busy); end
    tests_run++;
    if (bus.sample !== 4'b1010) begin tests_failed++; $display("FAIL full_sample got %b exp 1010", bus.sample); end
    step();
    tests_run++;
    if (bus.done !== 1'b0 || {bus.s1, bus.s0} !== 2'b11) begin tests_failed++; $display("FAIL full_after got done=%b sel=%b exp 0 11", bus.done, {bus.s1, bus.s0}); end
  endtask

  task automatic test_masked_scan();
    logic [1:0] exp_sel [4];
    exp_sel = '{2'b00, 2'b00, 2'b10, 2'b10};
    d = 4'b0110; bus.ch_en = 4'b0101; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if ({bus.s1, bus.s0} !== exp_sel[k] || bus.done !== 1'b0) begin
        tests_failed++;
        $display("FAIL masked_step%0d got sel=%b done=%b exp sel=%b done=0", k, {bus.s1, bus.s0}, bus.done, exp_sel[k]);
      end
      step();
    end
    tests_run++;
    if (bus.done !== 1'b1 || bus.sample !== 4'b0100) begin tests_failed++; $display("FAIL masked_done got done=%b sample=%b exp 1 0100", bus.done, bus.sample); end
    step();
  endtask

  task automatic test_reset_mid_scan();
    int seen;
    int ndone;
    d = 4'b0011; bus.ch_en = 4'b1111; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    tests_run++;
    if ({bus.s1, bus.s0} !== 2'b00 || bus.sample !== 4'b0000) begin tests_failed++; $display("FAIL rstmid_regs got sel=%b sample=%b exp 00 0000", {bus.s1, bus.s0}, bus.sample); end
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin tests_failed++; $display("FAIL rstmid_flags got busy=%b done=%b exp 0 0", bus.busy, bus.done); end
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
    end
    tests_run++;
    if (ndone !== 0) begin tests_failed++; $display("FAIL rstmid_quiet got %0d active cycles exp 0", ndone); end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    seen = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (bus.done === 1'b1) begin seen = k; break; end
    end
    tests_run++;
    if (seen !== 8) begin tests_failed++; $display("FAIL rstmid_rescan_latency got %0d exp 8", seen); end
    tests_run++;
    if (bus.sample !== 4'b0011) begin tests_failed++; $display("FAIL rstmid_rescan_sample got %b exp 0011", bus.sample); end
    step();
  endtask

  task automatic test_empty_mask();
    bus.ch_en = 4'b0000; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    tests_run++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin tests_failed++; $display("FAIL empty_done got done=%b busy=%b exp 1 0", bus.done, bus.busy); end
    tests_run++;
    if (bus.sample !== 4'b0000 || {bus.s1, bus.s0} !== 2'b11) begin tests_failed++; $display("FAIL empty_regs got sample=%b sel=%b exp 0000 11", bus.sample, {bus.s1, bus.s0}); end
    step();
    tests_run++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || {bus.s1, bus.s0} !== 2'b11) begin
      tests_failed++;
      $display("FAIL empty_after got done=%b busy=%b sel=%b exp 0 0 11", bus.done, bus.busy, {bus.s1, bus.s0});
    end
  endtask

  task automatic test_start_held();
    int seen;
    int ndone;
    d = 4'b1001; bus.ch_en = 4'b1010; bus.start = 1'b1;
    step();
    tests_run++;
    if ({bus.s1, bus.s0} !== 2'b01) begin tests_failed++; $display("FAIL held_first_sel got %b exp 01", {bus.s1, bus.s0}); end
    seen = -1;
    ndone = 0;
    for (int k = 1; k <= 12; k++) begin
      bus.ch_en = ~bus.ch_en;
      step();
      if (bus.done === 1'b1) begin
        ndone++;
        seen = k;
        bus.start = 1'b0;
        break;
      end
    end
    tests_run++;
    if (seen !== 4 || ndone !== 1) begin tests_failed++; $display("FAIL held_latency got cycle=%0d dones=%0d exp 4 1", seen, ndone); end
    tests_run++;
    if (bus.sample !== 4'b1000) begin tests_failed++; $display("FAIL held_sample got %b exp 1000", bus.sample); end
    step();
    tests_run++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin tests_failed++; $display("FAIL held_after got done=%b busy=%b exp 0 0", bus.done, bus.busy); end
  endtask

  task automatic test_continuous();
    logic [1:0] vals [4];
    logic [3:0] exp_s;
    int         ndone;
    vals = '{2'b01, 2'b10, 2'b11, 2'b00};
    d0 = {2'b00, vals[0]};
    exp_q.push_back({2'b00, vals[0]});
    bus0.ch_en = 4'b0011; bus0.cont = 1'b1; bus0.start = 1'b1;
    step();
    bus0.start = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (bus0.done === 1'b1) begin
        ndone++;
        tests_run++;
        if (k !== 2 + 3 * (ndone - 1)) begin tests_failed++; $display("FAIL cont_spacing%0d got cycle %0d exp %0d", ndone, k, 2 + 3 * (ndone - 1)); end
        exp_s = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bxxxx;
        tests_run++;
        if (bus0.sample !== exp_s) begin tests_failed++; $display("FAIL cont_sample%0d got %b exp %b", ndone, bus0.sample, exp_s); end
        if (ndone < 4) begin
          d0 = {2'b00, vals[ndone]};
          exp_q.push_back({2'b00, vals[ndone]});
        end else begin
          bus0.cont = 1'b0;
          break;
        end
      end
    end
    tests_run++;
    if (ndone !== 4 || exp_q.size() !== 0) begin tests_failed++; $display("FAIL cont_count got dones=%0d left=%0d exp 4 0", ndone, exp_q.size()); end
    step();
    tests_run++;
    if (bus0.done !== 1'b0 || bus0.busy !== 1'b0) begin tests_failed++; $display("FAIL cont_stop got done=%b busy=%b exp 0 0", bus0.done, bus0.busy); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_full_scan();
    test_masked_scan();
    test_reset_mid_scan();
    test_empty_mask();
    test_start_held();
    test_continuous();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "simulation did not complete");
  end

endmodule
